// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential BCD-to-binary converter (reverse double-dabble).
//               Takes a packed N_DIG-digit BCD value on a start strobe and
//               returns its binary equivalent after 4*N_DIG shift cycles.
//               Inputs containing a non-decimal digit are flagged with o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
  parameter int N_DIG = 2,
  parameter int BIN_W = 7,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [4*N_DIG-1:0] i_bcd,
  output logic               o_busy,
  output logic               o_done,
  output logic [BIN_W-1:0]   o_bin,
  output logic               o_err
);

  localparam int             C_W    = 4 * N_DIG;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [C_W-1:0]     d_q, d_d;
  logic [C_W-1:0]     b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic [C_W-1:0]     w_d_shift;
  logic [C_W-1:0]     w_d_corr;
  logic [C_W-1:0]     w_b_shift;
  logic [N_DIG-1:0]   w_dig_bad;
  logic               w_any_bad;

  // One bit moves from the bottom of D into the top of B per shift.
  assign w_d_shift = {1'b0, d_q[C_W-1:1]};
  assign w_b_shift = {d_q[0], b_q[C_W-1:1]};

  // Per-digit correction of the shifted D and validity check of the input.
  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    logic [3:0] w_dig;
    assign w_dig                  = w_d_shift[4*gi +: 4];
    assign w_d_corr[4*gi +: 4]    = (w_dig >= 4'd8) ? (w_dig - 4'd3) : w_dig;
    assign w_dig_bad[gi]          = (i_bcd[4*gi +: 4] > 4'd9);
  end

  assign w_any_bad = |w_dig_bad;

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (w_any_bad) begin
            // Bad digit: report immediately, skip the shift phase.
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            d_d     = i_bcd;
            b_d     = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        d_d   = w_d_corr;
        b_d   = w_b_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          // Last shift: the post-shift B holds the full binary value.
          bin_d   = w_b_shift[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign o_busy = (state_q == S_SHIFT);
  assign o_done = (state_q == S_DONE);
  assign o_bin  = bin_q;
  assign o_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_bin_seq
// Description : Self-checking bench for bcd_to_bin_seq. Directed scenarios
//               plus randomized conversions compared against a decimal
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bcd;
  logic       busy;
  logic       done;
  logic [6:0] bin;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_bin_seq #(.N_DIG(2), .BIN_W(7), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .i_bcd   (bcd),
    .o_busy  (busy),
    .o_done  (done),
    .o_bin   (bin),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the two digits, or error for a non-decimal digit.
  // lat = number of post-accept samples before Done is seen.
  function automatic void ref_model(input logic [7:0] v, output int e_bin,
                                    output int e_err, output int e_lat);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) begin
      e_bin = 0; e_err = 1; e_lat = 0;
    end else begin
      e_bin = hi * 10 + lo; e_err = 0; e_lat = 8;
    end
  endfunction

  // Full conversion from IDLE: accept, wait for Done, check result and pulse width.
  task automatic convert(input logic [7:0] v, input string tag);
    int e_bin, e_err, e_lat, n, nbusy;
    ref_model(v, e_bin, e_err, e_lat);
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcd   = 8'($urandom);
    n = 0; nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("%s done", tag), 32'(done), 32'd1);
    chk($sformatf("%s latency", tag), n, e_lat);
    chk($sformatf("%s busy cycles", tag), nbusy, e_lat);
    chk($sformatf("%s bin", tag), 32'(bin), e_bin);
    chk($sformatf("%s err", tag), 32'(err), e_err);
    @(posedge clk);
    #1;
    chk($sformatf("%s done pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s bin held", tag), 32'(bin), e_bin);
  endtask

  initial begin
    int n, ndone, last_i, first_i;
    logic [7:0] v;

    rst = 1'b1; start = 1'b0; bcd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset bin",  32'(bin),  32'd0);
    chk("reset err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values, including extremes and digit carry.
    convert(8'h42, "t42");
    convert(8'h99, "t99");
    convert(8'h00, "t00");
    convert(8'h10, "t10");
    convert(8'h3A, "t3A");
    convert(8'h37, "t37");
    convert(8'hA3, "tA3");

    // Start pulse and BCD change during SHIFT must not disturb the result.
    @(negedge clk);
    start = 1'b1; bcd = 8'h25;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; bcd = 8'h88;
    @(posedge clk);
    #1;
    start = 1'b0; bcd = 8'h11;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t25 done", 32'(done), 32'd1);
    chk("t25 bin", 32'(bin), 32'd25);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("t25 no extra done", ndone, 0);

    // Asynchronous reset in the 5th SHIFT cycle.
    @(negedge clk);
    start = 1'b1; bcd = 8'h76;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t76 busy before rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bin",  32'(bin),  32'd0);
    chk("rst err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("rst no done", ndone, 0);
    convert(8'h76, "t76");

    // Start held high: one result every 10 cycles.
    @(negedge clk);
    start = 1'b1; bcd = 8'h58;
    ndone = 0; last_i = -1; first_i = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        chk("b2b bin", 32'(bin), 32'd58);
        if (last_i < 0) first_i = i;
        else chk("b2b spacing", i - last_i, 10);
        last_i = i;
      end
    end
    start = 1'b0;
    chk("b2b count", ndone, 3);
    chk("b2b first", first_i, 8);
    repeat (3) @(posedge clk);

    // Randomized conversions, mostly valid with some non-decimal digits.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0)
        v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        v = 8'($urandom);
      convert(v, $sformatf("rnd%0d_%02h", k, v));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
